qdec_ctx_ctrl: RTL
==================

Name: qdec_ctx_ctrl

Overview:
- Controller in front of the CABAC context memory (1024 x 8, single address bus, registered read).
- At each slice start it sequences HEVC context initialisation: reads init values from the init-value ROM, computes the initial state from SliceQpY, and writes every context entry.
- Outside initialisation it grants the bin decoder's read/write requests to the memory.
- Owns the memory port exclusively.

Parameters:
- NUM_CTX, 256, number of contexts initialised per init type (1..256).
- ADDR_W, 10, context memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: begin context initialisation
- slice_qp  in  7  signed SliceQpY (-64..63)
- init_type  in  2  initType (0..2), sampled on start
- busy  out  1  high while initialising
- done  out  1  one-cycle pulse after the last context write
- rom_addr  out  10  init ROM address = {init_type, idx[7:0]}
- rom_rdata  in  8  initValue, valid 1 cycle after rom_addr
- cli_req  in  1  bin decoder access request
- cli_we  in  1  1 = write, 0 = read
- cli_addr  in  ADDR_W  context index
- cli_wdata  in  8  write data
- cli_gnt  out  1  request accepted this cycle
- cli_rvalid  out  1  read data valid
- cli_rdata  out  8  read data
- ctx_addr  out  ADDR_W  memory address
- ctx_wdata  out  8  memory write data
- ctx_we  out  1  memory write enable
- ctx_re  out  1  memory read enable
- ctx_rdata  in  8  memory read data, 1-cycle latency

Behaviour:
- Reset (asynchronous, any time including mid-init) clears all state and returns the block to IDLE.
  - Output values in reset: busy=0, done=0, cli_gnt=0, cli_rvalid=0, ctx_we=0, ctx_re=0, rom_addr=0, ctx_addr=0, ctx_wdata=0.
  - A partial initialisation is abandoned and is not resumed.
- State machine: IDLE -> INIT on start. INIT -> DRAIN after ROM index NUM_CTX-1 is issued. DRAIN -> IDLE after the last write. done pulses in the cycle after the last write.
- start while busy is ignored. slice_qp and init_type are latched on the start cycle.
- Init pipeline, 3 stages:
  - Cycle t: rom_addr = {init_type, idx}.
  - Cycle t+1: initValue is registered.
  - Cycle t+2: ctx_we=1, ctx_addr=idx, ctx_wdata = computed byte.
  - One context is processed per cycle. The first write occurs 2 cycles after start is seen; done asserts NUM_CTX+2 cycles after the start edge.
  - busy is high from the cycle after start through the last write.
- Arithmetic (HEVC 9.3.2.2), all signed:
  - qc = Clip3(0,51,slice_qp).
  - slope = initValue[7:4], offset = initValue[3:0].
  - m = slope*5-45, range -45..30, 7b signed.
  - n = (offset<<3)-16.
  - pre = Clip3(1,126,((m*qc)>>>4)+n). The product is at least 13b signed; the shift is arithmetic (floor).
  - valMps = (pre>63). pState = valMps ? pre-64 : 63-pre.
  - ctx_wdata = {1'b0, pState[5:0], valMps}.
- Client port:
  - cli_gnt = cli_req & ~busy, combinational. No client access is ever granted while busy.
  - The client holds cli_req until cli_gnt.
  - Granted write: drives ctx_we in the same cycle.
  - Granted read: drives ctx_re in the same cycle. cli_rvalid is asserted the next cycle, with cli_rdata = ctx_rdata.
  - Back-to-back reads are allowed, one per cycle.
- Simultaneous start and cli_req in IDLE: the client is granted in that cycle and init starts the next cycle. A read's rvalid still returns normally.
- ctx_we and ctx_re are never both high in the same cycle.

Test Plan:
- init_type=0, slice_qp=26, ROM[0]=154 -> write addr 0 data 0x01 (m=0, n=64, pre=64); done at cycle start+NUM_CTX+2.
- ROM[1]=139, qp=26 -> addr 1 data 0x00: (-130)>>>4 = -9, pre=63. Checks floor of a negative product.
- ROM[2]=63, qp=51 -> pre=8, data 0x6E. ROM[3]=0, qp=-6 (clipped to 0) -> pre clips -16 to 1, data 0x7C.
- cli_req read addr 5 during init -> cli_gnt=0 until done; then gnt in the first idle cycle, rvalid next cycle with the initialised value.
- Client write 0x55 to addr 7, then read addr 7 the next cycle -> rvalid with 0x55. start re-pulsed while busy -> ignored: exactly NUM_CTX writes, one done.
- rst asserted mid-init at idx 100 -> busy, we and done drop immediately. A new start re-initialises from idx 0.

Source files
------------

// File: rtl/qdec_ctx_ctrl.sv
// CABAC context memory controller: HEVC context init at slice start,
// otherwise arbitrates bin-decoder reads/writes onto the memory port.
// Ports: clk, rst (async, active high), start/slice_qp/init_type (init
// request), busy/done (status), rom_addr/rom_rdata (init-value ROM),
// cli_* (bin decoder access), ctx_* (context memory, 1-cycle read).
module qdec_ctx_ctrl #(
  parameter int NUM_CTX = 256,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        slice_qp,
  input  logic [1:0]        init_type,
  output logic              busy,
  output logic              done,
  output logic [9:0]        rom_addr,
  input  logic [7:0]        rom_rdata,
  input  logic              cli_req,
  input  logic              cli_we,
  input  logic [ADDR_W-1:0] cli_addr,
  input  logic [7:0]        cli_wdata,
  output logic              cli_gnt,
  output logic              cli_rvalid,
  output logic [7:0]        cli_rdata,
  output logic [ADDR_W-1:0] ctx_addr,
  output logic [7:0]        ctx_wdata,
  output logic              ctx_we,
  output logic              ctx_re,
  input  logic [7:0]        ctx_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    DRAIN
  } state_t;

  localparam logic [7:0] LAST = 8'(NUM_CTX - 1);

  state_t            state;
  logic [5:0]        qc;
  logic              v1;
  logic [7:0]        idx1;
  logic              iw_we;
  logic [ADDR_W-1:0] iw_addr;
  logic [7:0]        iw_data;

  logic [5:0]        qc_in;
  logic signed [15:0] m;
  logic signed [15:0] n;
  logic signed [15:0] prod;
  logic signed [15:0] sum;
  logic [6:0]        pre;
  logic [5:0]        pst;
  logic [7:0]        calc;

  logic              cli_wr;
  logic              cli_rd;

  always_comb begin
    qc_in = slice_qp[5:0];
    if (slice_qp[6])
      qc_in = 6'd0;
    else if (slice_qp[5:0] > 6'd51)
      qc_in = 6'd51;
  end

  // Context init arithmetic on the ROM byte that arrives this cycle.
  always_comb begin
    m    = $signed({12'd0, rom_rdata[7:4]}) * 16'sd5 - 16'sd45;
    n    = $signed({9'd0, rom_rdata[3:0], 3'd0}) - 16'sd16;
    prod = m * $signed({10'd0, qc});
    sum  = (prod >>> 4) + n;
    pre  = sum[6:0];
    if (sum < 16'sd1)
      pre = 7'd1;
    else if (sum > 16'sd126)
      pre = 7'd126;
    // pre is 1..126, so bit 6 is valMps and the low bits give pState
    pst  = pre[6] ? pre[5:0] : 6'd63 - pre[5:0];
    calc = {1'b0, pst, pre[6]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rom_addr   <= '0;
      qc         <= '0;
      v1         <= 1'b0;
      idx1       <= '0;
      iw_we      <= 1'b0;
      iw_addr    <= '0;
      iw_data    <= '0;
      cli_rvalid <= 1'b0;
    end else begin
      done       <= 1'b0;
      v1         <= 1'b0;
      iw_we      <= v1;
      cli_rvalid <= cli_rd;
      if (v1) begin
        iw_addr <= ADDR_W'(idx1);
        iw_data <= calc;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= INIT;
            busy     <= 1'b1;
            qc       <= qc_in;
            rom_addr <= {init_type, 8'd0};
          end
        end
        INIT: begin
          v1   <= 1'b1;
          idx1 <= rom_addr[7:0];
          if (rom_addr[7:0] == LAST)
            state <= DRAIN;
          else
            rom_addr[7:0] <= rom_addr[7:0] + 8'd1;
        end
        DRAIN: begin
          // last write is the one with nothing left behind it
          if (iw_we && !v1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cli_gnt   = cli_req & ~busy & ~rst;
  assign cli_wr    = cli_gnt & cli_we;
  assign cli_rd    = cli_gnt & ~cli_we;
  assign cli_rdata = ctx_rdata;

  assign ctx_we    = iw_we | cli_wr;
  assign ctx_re    = cli_rd;
  assign ctx_addr  = cli_gnt ? cli_addr : iw_addr;
  assign ctx_wdata = cli_wr ? cli_wdata : iw_data;

endmodule
